// File: rtl/knight_rider_pkg.sv
// Shared types and constants for the knight_rider LED scanner and its bus checkers.
package knight_rider_pkg;

  localparam int unsigned LedWidth = 8;

  typedef enum logic [1:0] {
    StUnlocked,
    StAcquire,
    StLocked
  } kr_state_e;

  localparam logic [1:0] ErrNone   = 2'd0;
  localparam logic [1:0] ErrOnehot = 2'd1;
  localparam logic [1:0] ErrStep   = 2'd2;
  localparam logic [1:0] ErrStall  = 2'd3;

endpackage

// File: rtl/onehot_encode.sv
// Combinational one-hot detector and binary encoder for an LED bus.
module onehot_encode #(
  parameter int unsigned Width = 8,
  parameter int unsigned PosW  = $clog2(Width)
) (
  input  logic [Width-1:0] vec_i,
  output logic             onehot_o,
  output logic [PosW-1:0]  idx_o
);

  always_comb begin
    onehot_o = $onehot(vec_i);
    idx_o    = '0;
    // Index is only meaningful when onehot_o is set.
    for (int i = 0; i < int'(Width); i++) begin
      if (vec_i[i]) begin
        idx_o = PosW'(i);
      end
    end
  end

endmodule

// File: rtl/knight_rider_monitor.sv
// Receive-side checker for the knight_rider scanner: tracks position, direction and
// sweeps of the single lit LED and flags non-one-hot, illegal-step and stall violations.
module knight_rider_monitor
  import knight_rider_pkg::*;
#(
  parameter int unsigned WIDTH          = LedWidth,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
  parameter int unsigned CNT_W          = 16,
  localparam int unsigned POS_W         = $clog2(WIDTH)
) (
  input  logic             clki,
  input  logic             reset,
  input  logic [WIDTH-1:0] leds,
  output logic             locked,
  output logic [POS_W-1:0] pos,
  output logic             dir,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] sweep_count,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WIDTH-1:0] leds_s_q, leds_last_q;
  kr_state_e        state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             dir_q, dir_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] sweep_q, sweep_d;
  logic [CNT_W-1:0] errcnt_q, errcnt_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;

  logic             evt;
  logic             oh;
  logic [POS_W-1:0] idx;
  logic [POS_W-1:0] exp_idx;
  logic             exp_rev;
  logic             adjacent;

  onehot_encode #(
    .Width (WIDTH),
    .PosW  (POS_W)
  ) u_onehot_encode (
    .vec_i    (leds_s_q),
    .onehot_o (oh),
    .idx_o    (idx)
  );

  assign evt      = (leds_s_q != leds_last_q);
  // Widened by one bit so pos+1 cannot wrap at the top end.
  assign adjacent = ({1'b0, idx} == {1'b0, pos_q} + 1'b1) ||
                    ({1'b0, pos_q} == {1'b0, idx} + 1'b1);

  always_comb begin
    exp_rev = 1'b0;
    exp_idx = pos_q;
    if (dir_q) begin
      if (pos_q == POS_W'(WIDTH - 1)) begin
        exp_idx = POS_W'(WIDTH - 2);
        exp_rev = 1'b1;
      end else begin
        exp_idx = pos_q + 1'b1;
      end
    end else begin
      if (pos_q == '0) begin
        exp_idx = POS_W'(1);
        exp_rev = 1'b1;
      end else begin
        exp_idx = pos_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dir_d      = dir_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    sweep_d    = sweep_q;
    errcnt_d   = errcnt_q;

    unique case (state_q)
      StUnlocked: begin
        if (evt && oh) begin
          pos_d   = idx;
          state_d = StAcquire;
        end
      end
      StAcquire: begin
        if (evt) begin
          if (!oh) begin
            state_d = StUnlocked;
          end else if (adjacent) begin
            dir_d   = (idx > pos_q);
            pos_d   = idx;
            state_d = StLocked;
          end else begin
            pos_d = idx;
          end
        end
      end
      StLocked: begin
        if (evt) begin
          if (oh && (idx == exp_idx)) begin
            pos_d = idx;
            if (exp_rev) begin
              dir_d   = ~dir_q;
              sweep_d = sweep_q + 1'b1;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = oh ? ErrStep : ErrOnehot;
            if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
            if (oh) begin
              pos_d   = idx;
              state_d = StAcquire;
            end else begin
              state_d = StUnlocked;
            end
          end
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          err_d      = 1'b1;
          err_code_d = ErrStall;
          if (errcnt_q != '1) errcnt_d = errcnt_q + 1'b1;
          state_d    = StUnlocked;
        end
      end
      default: state_d = StUnlocked;
    endcase
  end

  always_comb begin
    tmo_d = tmo_q;
    if (evt || (state_d != state_q)) begin
      tmo_d = '0;
    end else if (state_q == StLocked) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clki) begin
    if (reset) begin
      leds_s_q    <= '0;
      leds_last_q <= '0;
      state_q     <= StUnlocked;
      pos_q       <= '0;
      dir_q       <= 1'b1;
      err_q       <= 1'b0;
      err_code_q  <= ErrNone;
      sweep_q     <= '0;
      errcnt_q    <= '0;
      tmo_q       <= '0;
    end else begin
      leds_s_q    <= leds;
      leds_last_q <= leds_s_q;
      state_q     <= state_d;
      pos_q       <= pos_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      sweep_q     <= sweep_d;
      errcnt_q    <= errcnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign locked      = (state_q == StLocked);
  assign pos         = pos_q;
  assign dir         = dir_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign sweep_count = sweep_q;
  assign err_count   = errcnt_q;

endmodule

// File: doc/knight_rider_monitor.md
Name: knight_rider_monitor

Overview:
- Receive-side checker for the knight_rider LED scanner: watches the 8-bit LED bus and decodes the position, direction and sweep count of the bouncing single lit LED.
- Flags protocol violations: non-one-hot patterns, skipped positions, wrong-way moves and stalls.
- Sits beside knight_rider in board top-levels and benches as a self-checking monitor; its outputs can also drive a debug UART or a 7-segment display.

Parameters:
- WIDTH, 8: number of LEDs observed; must be ≥ 2.
- POS_W, $clog2(WIDTH): width of the position output; derived, not overridden.
- TIMEOUT_CYCLES, 50_000_000: maximum number of clki cycles without any LED change while LOCKED before a stall error fires.
- CNT_W, 16: width of sweep_count and err_count.

Ports:
- clki, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- leds, input, WIDTH: observed LED bus, synchronous to clki.
- locked, output, 1: high while a legal scan is being tracked.
- pos, output, POS_W: index of the lit LED; bit 0 = position 0.
- dir, output, 1: direction of the last legal move; 1 = upward (toward index WIDTH-1), 0 = downward.
- err, output, 1: one-cycle pulse on each detected violation.
- err_code, output, 2: cause of the most recent error, held until the next error.
  - 0 = none
  - 1 = not one-hot
  - 2 = illegal step
  - 3 = stall
- sweep_count, output, CNT_W: number of end-point reversals seen while LOCKED; wraps modulo 2^CNT_W.
- err_count, output, CNT_W: total errors; saturates at all-ones.

Behaviour:
- Reset (reset sampled high at a clki edge):
  - state = UNLOCKED; locked = 0, pos = 0, dir = 1, err = 0, err_code = 0, sweep_count = 0, err_count = 0.
  - Input register and timeout counter are cleared.
  - Reset overrides all other activity in that cycle.
- Input stage:
  - leds is registered into leds_s.
  - leds_last holds the previous leds_s.
  - An event occurs in a cycle where leds_s != leds_last.
  - Outputs update on the edge after the event is detected. A change on leds appears on the outputs 2 edges after it is sampled.
- onehot = leds_s has exactly one bit set. An all-zero value is not one-hot.
- State machine (evaluated only on events, except the timeout):
  - UNLOCKED:
    - onehot: pos <= index, go to ACQUIRE.
    - otherwise: stay. No errors are reported while UNLOCKED.
  - ACQUIRE:
    - onehot and index = pos ± 1: dir <= (index > pos), pos <= index, locked <= 1, go to LOCKED.
    - onehot but not adjacent: pos <= index, stay in ACQUIRE.
    - not onehot: go to UNLOCKED.
  - LOCKED, expected next index:
    - dir = 1 and pos < WIDTH-1: pos+1.
    - dir = 1 and pos = WIDTH-1: WIDTH-2, with dir <= 0 and sweep_count++.
    - dir = 0 and pos > 0: pos-1.
    - dir = 0 and pos = 0: 1, with dir <= 1 and sweep_count++.
  - LOCKED, matching event: update pos; go to LOCKED.
  - LOCKED, non-matching event:
    - err pulse; err_count++ (saturating); locked <= 0.
    - err_code = 1 if not onehot, else 2.
    - Next state is ACQUIRE with pos <= index if onehot, else UNLOCKED.
- Timeout:
  - The counter clears on every event and on any state change.
  - It increments each cycle only in LOCKED.
  - When it reaches TIMEOUT_CYCLES-1 with no event: err pulse, err_code = 3, err_count++, go to UNLOCKED, locked <= 0.
  - If an event and the timeout coincide, the event wins and the counter clears.
- A mid-sweep reset is legal. Because the input registers clear on reset, the first post-reset LED value is treated as an event, and reacquisition takes 2 LED events.
- Counters:
  - sweep_count wraps: 0xFFFF + 1 = 0x0000 at CNT_W = 16.
  - err_count sticks at 0xFFFF.

Decomposition:
- Shared package knight_rider_pkg holds:
  - the state enum (UNLOCKED, ACQUIRE, LOCKED);
  - the err_code constants (ERR_NONE, ERR_ONEHOT, ERR_STEP, ERR_STALL);
  - the default LED width of 8, shared with knight_rider.
- One sub-module, onehot_encode: combinational; WIDTH-bit vector in, outputs onehot flag and POS_W index. Reused by other LED-bus checkers.
- Timeout counter and state machine stay in the top module.

Test Plan (WIDTH=8, TIMEOUT_CYCLES=16, each LED value held 4 cycles):
1. Reset, then drive 01,02,04,08 -> locked = 1 two edges after 02 is sampled; pos = 3, dir = 1 after 08; err never pulses.
2. Full bounce 01..80 then 40..01 then 02 -> sweep_count = 2 (reversals at 80 and at 01); dir = 0 while descending; no err.
3. While locked at pos = 3 going up (dir = 1), drive 20 -> single-cycle err, err_code = 2, err_count = 1, locked = 0; following 40 relocks with pos = 6, dir = 1.
4. While locked, drive 0x18 -> err, err_code = 1, state UNLOCKED; next 08 goes to ACQUIRE only, locked stays 0 until 10.
5. While locked, hold leds constant for 20 cycles -> err exactly once after 16 cycles, err_code = 3, locked = 0; no second err.
6. Assert reset for 1 cycle mid-sweep -> all outputs zero except dir = 1 on the next edge; relock after 2 further LED steps. Separately, force err_count near 0xFFFF -> count saturates at 0xFFFF.
